// File: rtl/cpu_seq_pkg.sv
// Shared types for the cpu_sequencer control slice.
// Latency: n/a (types, constants and a state classifier only).
// Backpressure: n/a.
package cpu_seq_pkg;

  // Instruction step states; 3 bits covers all eight.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6,
    ST_FAULT  = 3'd7
  } seq_state_t;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
  localparam logic [1:0] FAULT_IMEM_TO = 2'b10;
  localparam logic [1:0] FAULT_DMEM_TO = 2'b11;

  // True while an instruction is in flight (FETCH through WB).
  function automatic logic seq_is_busy(input seq_state_t s);
    return (s == ST_FETCH) || (s == ST_DECODE) || (s == ST_EXEC) ||
           (s == ST_MEM) || (s == ST_WB);
  endfunction

endpackage

// File: rtl/cpu_sequencer_mem_wait_timer.sv
// Memory-ack wait counter shared by the FETCH and MEM handshakes.
// Latency: expired is combinational from the count; it rises on the TIMEOUT-th wait cycle.
// Backpressure: none; the counter freezes at its limit until cleared.
module mem_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [7:0] r_cnt;

  assign expired = (r_cnt == 8'(TIMEOUT - 1));

  // Count unacknowledged wait cycles; clear holds the count at zero between handshakes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= 8'd0;
    end else if (clr) begin
      r_cnt <= 8'd0;
    end else if (en && !expired) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: FETCH, DECODE, EXEC, [MEM], WB with fault and halt handling.
// Latency: 4 cycles per non-memory instruction, 5 per load/store with zero-wait memory.
// Backpressure: req held until ack; a wait of TIMEOUT cycles faults. SEQ_PERF_CNT_EN adds cycle/instr counters.
module cpu_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int PERF_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              halt_req,
  input  logic              dec_valid,
  input  logic              dec_reg_write,
  input  logic              dec_data_read,
  input  logic              dec_data_write,
  output logic              imem_req,
  input  logic              imem_ack,
  output logic              dmem_req,
  output logic              dmem_we,
  input  logic              dmem_ack,
  output logic              ir_load,
  output logic              rf_we,
  output logic              pc_we,
  output logic              busy,
  output logic              halted,
  output logic [1:0]        fault_code
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] cycle_cnt,
  output logic [PERF_W-1:0] instr_cnt
`endif
);

  seq_state_t r_state;
  seq_state_t w_state_nxt;
  logic [1:0] r_fault_code;
  logic [1:0] w_fault_nxt;
  logic       w_dec_illegal;
  logic       w_dec_mem;
  logic       w_tmr_clr;
  logic       w_tmr_en;
  logic       w_tmr_expired;

  assign w_dec_illegal = !dec_valid || (dec_data_read && dec_data_write);
  assign w_dec_mem     = dec_data_read || dec_data_write;

  // Timer sits at zero outside the two wait states, so each FETCH/MEM entry starts fresh.
  assign w_tmr_clr = !((r_state == ST_FETCH) || (r_state == ST_MEM));
  assign w_tmr_en  = ((r_state == ST_FETCH) && !imem_ack) ||
                     ((r_state == ST_MEM) && !dmem_ack);

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (w_tmr_clr),
    .en      (w_tmr_en),
    .expired (w_tmr_expired)
  );

  // State and sticky fault code; async reset drops every request immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_fault_code <= FAULT_NONE;
    end else begin
      r_state      <= w_state_nxt;
      r_fault_code <= w_fault_nxt;
    end
  end

  // Next state, fault capture and state-decoded enables/requests.
  always_comb begin
    w_state_nxt = r_state;
    w_fault_nxt = r_fault_code;
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    ir_load     = 1'b0;
    rf_we       = 1'b0;
    pc_we       = 1'b0;
    halted      = 1'b0;
    busy        = seq_is_busy(r_state);
    case (r_state)
      ST_IDLE: begin
        if (run) w_state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        // An ack on the final allowed wait cycle still wins over the timeout.
        if (imem_ack) begin
          ir_load     = 1'b1;
          w_state_nxt = ST_DECODE;
        end else if (w_tmr_expired) begin
          w_state_nxt = ST_FAULT;
          w_fault_nxt = FAULT_IMEM_TO;
        end
      end
      ST_DECODE: begin
        if (w_dec_illegal) begin
          w_state_nxt = ST_FAULT;
          w_fault_nxt = FAULT_ILLEGAL;
        end else begin
          w_state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        w_state_nxt = w_dec_mem ? ST_MEM : ST_WB;
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = dec_data_write;
        if (dmem_ack) begin
          w_state_nxt = ST_WB;
        end else if (w_tmr_expired) begin
          w_state_nxt = ST_FAULT;
          w_fault_nxt = FAULT_DMEM_TO;
        end
      end
      ST_WB: begin
        pc_we       = 1'b1;
        rf_we       = dec_reg_write && !dec_data_write;
        w_state_nxt = halt_req ? ST_HALT : ST_FETCH;
      end
      ST_HALT: begin
        halted = 1'b1;
        if (run) w_state_nxt = ST_FETCH;
      end
      ST_FAULT: begin
        w_state_nxt = ST_FAULT;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign fault_code = r_fault_code;

`ifdef SEQ_PERF_CNT_EN
  logic [PERF_W-1:0] r_cycle_cnt;
  logic [PERF_W-1:0] r_instr_cnt;

  // Active-cycle and retired-instruction counters, free-running with natural wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cycle_cnt <= '0;
      r_instr_cnt <= '0;
    end else begin
      if (busy) r_cycle_cnt <= r_cycle_cnt + PERF_W'(1);
      if (r_state == ST_WB) r_instr_cnt <= r_instr_cnt + PERF_W'(1);
    end
  end

  assign cycle_cnt = r_cycle_cnt;
  assign instr_cnt = r_instr_cnt;
`else
  // PERF_W only sizes the counters; without them it has no hardware to shape.
  if (PERF_W < 1) begin : g_perf_w_unused
  end
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Randomised bench for cpu_sequencer against a transaction-level expectation model.
// Latency: n/a.
// Backpressure: bench plays both memories with per-instruction programmed ack delays.
module tb_cpu_sequencer;

  localparam int TO = 16;
  localparam int PW = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       run = 1'b0;
  logic       halt_req = 1'b0;
  logic       dec_valid = 1'b0;
  logic       dec_reg_write = 1'b0;
  logic       dec_data_read = 1'b0;
  logic       dec_data_write = 1'b0;
  logic       imem_ack = 1'b0;
  logic       dmem_ack = 1'b0;
  logic       imem_req, dmem_req, dmem_we, ir_load, rf_we, pc_we, busy, halted;
  logic [1:0] fault_code;
`ifdef SEQ_PERF_CNT_EN
  logic [PW-1:0] cycle_cnt, instr_cnt;
`endif

  int     n_tests = 0;
  int     n_fail  = 0;
  longint m_cycles = 0;
  longint m_instrs = 0;

  always #5 clk = ~clk;

  cpu_sequencer #(
    .TIMEOUT (TO),
    .PERF_W  (PW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .run            (run),
    .halt_req       (halt_req),
    .dec_valid      (dec_valid),
    .dec_reg_write  (dec_reg_write),
    .dec_data_read  (dec_data_read),
    .dec_data_write (dec_data_write),
    .imem_req       (imem_req),
    .imem_ack       (imem_ack),
    .dmem_req       (dmem_req),
    .dmem_we        (dmem_we),
    .dmem_ack       (dmem_ack),
    .ir_load        (ir_load),
    .rf_we          (rf_we),
    .pc_we          (pc_we),
    .busy           (busy),
    .halted         (halted),
    .fault_code     (fault_code)
`ifdef SEQ_PERF_CNT_EN
    ,
    .cycle_cnt      (cycle_cnt),
    .instr_cnt      (instr_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

`ifdef SEQ_PERF_CNT_EN
  task automatic chk_perf(input string tag);
    chk({tag, "_cycle_cnt"}, 64'(cycle_cnt), m_cycles);
    chk({tag, "_instr_cnt"}, 64'(instr_cnt), m_instrs);
  endtask
`endif

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; run = 1'b0; halt_req = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    m_cycles = 0; m_instrs = 0;
    #1;
    chk("rst_outputs", {imem_req, dmem_req, dmem_we, ir_load, rf_we, pc_we, busy, halted, fault_code}, 0);
`ifdef SEQ_PERF_CNT_EN
    chk_perf("rst");
`endif
    @(negedge clk);
    rst = 1'b0; run = 1'b1;
  endtask

  // kind: 0 ALU write, 1 ALU no-write, 2 load, 3 store, 4 dec_valid=0, 5 read+write.
  // idly/ddly: wait cycles before ack (>= TO means ack never arrives in time).
  task automatic do_instr(input int kind, input int idly, input int ddly, input bit hreq,
                          output bit need_rst);
    bit         is_mem, illegal, i_to, d_to, done, first_busy;
    int         exp_busy, exp_rf, exp_dreq, cyc, n_ir, n_pc, n_rf, n_ireq, n_dreq;
    int         ir_at, pc_at, we_err;
    logic [1:0] exp_fc;

    is_mem  = (kind == 2) || (kind == 3);
    illegal = (kind >= 4);
    i_to    = (idly >= TO);
    d_to    = !i_to && !illegal && is_mem && (ddly >= TO);
    exp_rf  = (kind == 0 || kind == 2) ? 1 : 0;
    if (i_to) begin
      exp_busy = TO;                exp_fc = 2'b10; exp_dreq = 0;
    end else if (illegal) begin
      exp_busy = idly + 2;          exp_fc = 2'b01; exp_dreq = 0;
    end else if (d_to) begin
      exp_busy = idly + 3 + TO;     exp_fc = 2'b11; exp_dreq = TO;
    end else begin
      exp_busy = idly + 4 + (is_mem ? ddly + 1 : 0);
      exp_fc = 2'b00;
      exp_dreq = is_mem ? ddly + 1 : 0;
    end

    dec_valid      = (kind != 4);
    dec_reg_write  = (kind == 0 || kind == 2) || ((kind >= 3) && ($urandom_range(0, 1) == 1));
    dec_data_read  = (kind == 2) || (kind == 5);
    dec_data_write = (kind == 3) || (kind == 5);

    cyc = 0; n_ir = 0; n_pc = 0; n_rf = 0; n_ireq = 0; n_dreq = 0;
    ir_at = 0; pc_at = 0; we_err = 0; done = 1'b0; first_busy = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      run = 1'b0;
      imem_ack = imem_req && (n_ireq == idly);
      if (imem_req) n_ireq++;
      dmem_ack = dmem_req && (n_dreq == ddly);
      if (dmem_req) begin
        n_dreq++;
        if (dmem_we !== dec_data_write) we_err++;
      end
      halt_req = hreq && (n_ir > 0);
      #1;
      if (c == 0) first_busy = busy;
      if (busy) cyc++;
      if (ir_load) begin n_ir++; ir_at = cyc; end
      if (rf_we) begin n_rf++; if (!pc_we) we_err++; end
      if (pc_we) begin n_pc++; pc_at = cyc; end
      done = pc_we || (fault_code != 2'b00);
    end

    chk("instr_done", done, 1);
    chk("first_cycle_busy", first_busy, 1);
    chk("busy_cycles", cyc, exp_busy);
    chk("ir_load_count", n_ir, i_to ? 0 : 1);
    if (!i_to) chk("ir_load_cycle", ir_at, idly + 1);
    chk("imem_req_cycles", n_ireq, i_to ? TO : idly + 1);
    chk("dmem_req_cycles", n_dreq, exp_dreq);
    chk("dmem_we_rf_we_errors", we_err, 0);
    chk("fault_code", fault_code, exp_fc);
    chk("pc_we_count", n_pc, (exp_fc == 2'b00) ? 1 : 0);
    chk("rf_we_count", n_rf, (exp_fc == 2'b00) ? exp_rf : 0);
    if (exp_fc == 2'b00) chk("wb_cycle", pc_at, exp_busy);

    m_cycles += exp_busy;
    if (exp_fc == 2'b00) m_instrs++;
    need_rst = (exp_fc != 2'b00);

    if (need_rst) begin
      chk("fault_reqs_low", {imem_req, dmem_req, busy, pc_we, rf_we}, 0);
      run = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk("fault_sticky", {busy, imem_req, halted, fault_code}, {3'b000, exp_fc});
`ifdef SEQ_PERF_CNT_EN
      chk_perf("fault");
`endif
    end else if (hreq) begin
      @(negedge clk);
      halt_req = 1'b0;
      #1;
      chk("halt_state", {halted, busy, imem_req}, 3'b100);
`ifdef SEQ_PERF_CNT_EN
      chk_perf("halt");
`endif
      run = 1'b1;
    end
  endtask

  initial begin
    bit need_rst;
    bit seen;
    int kind, idly, ddly, r;
    bit hreq;

    do_reset();

    // Directed: ADD, loads/stores with wait, halt, ack-on-boundary cases.
    do_instr(0, 0, 0, 1'b0, need_rst);
    do_instr(2, 0, 3, 1'b0, need_rst);
    do_instr(3, 0, 3, 1'b1, need_rst);
    do_instr(2, 1, 2, 1'b1, need_rst);
    do_instr(1, TO - 1, 0, 1'b0, need_rst);
    do_instr(2, 1, TO - 1, 1'b0, need_rst);
    do_instr(4, 0, 0, 1'b0, need_rst);
    do_reset();
    do_instr(5, 2, 0, 1'b0, need_rst);
    do_reset();
    do_instr(0, TO + 5, 0, 1'b0, need_rst);
    do_reset();
    do_instr(3, 0, TO + 2, 1'b0, need_rst);
    do_reset();

    // Random mix of instruction kinds, memory delays and halts.
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 15);
      kind = (r < 14) ? (r % 4) : ((r == 14) ? 4 : 5);
      idly = ($urandom_range(0, 24) == 0) ? $urandom_range(TO - 1, TO + 1) : $urandom_range(0, 3);
      ddly = ($urandom_range(0, 12) == 0) ? $urandom_range(TO - 1, TO + 1) : $urandom_range(0, 4);
      hreq = ($urandom_range(0, 4) == 0);
      do_instr(kind, idly, ddly, hreq, need_rst);
      if (need_rst) do_reset();
    end

    // Reset in the middle of a data handshake drops the request asynchronously.
    do_reset();
    dec_valid = 1'b1; dec_reg_write = 1'b1; dec_data_read = 1'b1; dec_data_write = 1'b0;
    seen = 1'b0;
    for (int w = 0; w < 20 && !seen; w++) begin
      @(negedge clk);
      run = 1'b0;
      imem_ack = imem_req;
      dmem_ack = 1'b0;
      #1;
      seen = dmem_req;
    end
    chk("mem_reached", seen, 1);
    @(negedge clk);
    #1;
    chk("mem_still_req", dmem_req, 1);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_outputs", {imem_req, dmem_req, dmem_we, ir_load, rf_we, pc_we, busy, halted, fault_code}, 0);
    do_reset();

    // Ten zero-wait ADDs then halt: counters settle at 10 instructions / 40 cycles.
    for (int i = 0; i < 10; i++) do_instr(0, 0, 0, (i == 9), need_rst);
`ifdef SEQ_PERF_CNT_EN
    chk("ten_add_instr_cnt", 64'(instr_cnt), 10);
    chk("ten_add_cycle_cnt", 64'(cycle_cnt), 40);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
